// File: rtl/comparator_2bit_sync.sv
// Two-bit unsigned magnitude comparator with a registered result on out1.
// Optional registered eq/lt flags are added when COMPARATOR_FLAGS_EN is defined.
module comparator_2bit_sync #(
   parameter int CMP_MODE = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic in1,
   input  logic in2,
   input  logic in3,
   input  logic in4,
`ifdef COMPARATOR_FLAGS_EN
   output logic out_eq,
   output logic out_lt,
`endif
   output logic out1
);

   logic [1:0] a;
   logic [1:0] b;
   logic       gt;
   logic       eq;
   logic       lt;
   logic       sel;

   assign a  = {in1, in2};
   assign b  = {in3, in4};
   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);

   // Unsupported modes fall back to the A>B relation.
   always_comb begin
      // NOTE: default assigned first so no path through the case can infer a latch.
      sel = gt;
      case (CMP_MODE)
         1:       sel = eq;
         2:       sel = lt;
         3:       sel = gt | eq;
         default: sel = gt;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         out1 <= 1'b0;
      end else begin
         out1 <= sel;
      end
   end

`ifdef COMPARATOR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_eq <= 1'b0;
         out_lt <= 1'b0;
      end else begin
         out_eq <= eq;
         out_lt <= lt;
      end
   end
`endif

endmodule

// File: tb/tb_comparator_2bit_sync.sv
// Self-checking bench for comparator_2bit_sync: all four modes plus an out-of-range mode,
// table vectors, exhaustive sweep, random stimulus, latency and reset corner cases.
module tb_comparator_2bit_sync;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in1 = 1'b0;
   logic in2 = 1'b0;
   logic in3 = 1'b0;
   logic in4 = 1'b0;
   logic outm [5];
`ifdef COMPARATOR_FLAGS_EN
   logic out_eq;
   logic out_lt;
   logic eq_unused [1:4];
   logic lt_unused [1:4];
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Index 0..3 are modes 0..3; index 4 uses an out-of-range mode that must act like mode 0.
`ifdef COMPARATOR_FLAGS_EN
   comparator_2bit_sync #(.CMP_MODE(0)) u_m0 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out_eq(out_eq), .out_lt(out_lt), .out1(outm[0]));
   comparator_2bit_sync #(.CMP_MODE(1)) u_m1 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out_eq(eq_unused[1]), .out_lt(lt_unused[1]), .out1(outm[1]));
   comparator_2bit_sync #(.CMP_MODE(2)) u_m2 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out_eq(eq_unused[2]), .out_lt(lt_unused[2]), .out1(outm[2]));
   comparator_2bit_sync #(.CMP_MODE(3)) u_m3 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out_eq(eq_unused[3]), .out_lt(lt_unused[3]), .out1(outm[3]));
   comparator_2bit_sync #(.CMP_MODE(7)) u_m7 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out_eq(eq_unused[4]), .out_lt(lt_unused[4]), .out1(outm[4]));
`else
   comparator_2bit_sync #(.CMP_MODE(0)) u_m0 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out1(outm[0]));
   comparator_2bit_sync #(.CMP_MODE(1)) u_m1 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out1(outm[1]));
   comparator_2bit_sync #(.CMP_MODE(2)) u_m2 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out1(outm[2]));
   comparator_2bit_sync #(.CMP_MODE(3)) u_m3 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out1(outm[3]));
   comparator_2bit_sync #(.CMP_MODE(7)) u_m7 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out1(outm[4]));
`endif

   // Expected bits packed as {ge, lt, eq, gt}, i.e. bit i is the result for mode i.
   typedef struct {
      logic [3:0] vec;
      logic [3:0] exp;
   } vec_t;

   function automatic logic model(input int mode, input logic [3:0] v);
      int a;
      int b;
      a = 2 * int'(v[3]) + int'(v[2]);
      b = 2 * int'(v[1]) + int'(v[0]);
      case (mode)
         1:       return logic'(a == b);
         2:       return logic'(a < b);
         3:       return logic'(a >= b);
         default: return logic'(a > b);
      endcase
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] v);
      {in1, in2, in3, in4} = v;
   endtask

   // Compare every instance against the model for the vector registered at the last edge.
   task automatic check_all(input string tag, input logic [3:0] v);
      for (int m = 0; m < 4; m++)
         check($sformatf("%s vec=%b mode%0d", tag, v, m), outm[m], model(m, v));
      check($sformatf("%s vec=%b mode7", tag, v), outm[4], model(7, v));
`ifdef COMPARATOR_FLAGS_EN
      check($sformatf("%s vec=%b out_eq", tag, v), out_eq, model(1, v));
      check($sformatf("%s vec=%b out_lt", tag, v), out_lt, model(2, v));
      check($sformatf("%s vec=%b onehot", tag, v), logic'($countones({outm[0], out_eq, out_lt}) == 1), 1'b1);
`endif
   endtask

   task automatic apply(input string tag, input logic [3:0] v);
      drive(v);
      @(posedge clk);
      #1;
      check_all(tag, v);
   endtask

   initial begin
      vec_t tbl [9];
      tbl[0] = '{4'b1000, 4'b1001};
      tbl[1] = '{4'b0010, 4'b0100};
      tbl[2] = '{4'b1111, 4'b1010};
      tbl[3] = '{4'b1010, 4'b1010};
      tbl[4] = '{4'b0000, 4'b1010};
      tbl[5] = '{4'b1100, 4'b1001};
      tbl[6] = '{4'b0011, 4'b0100};
      tbl[7] = '{4'b0110, 4'b0100};
      tbl[8] = '{4'b1001, 4'b1001};

      // Reset held for two edges with all inputs high (A==B would otherwise set modes 1 and 3).
      rst = 1'b1;
      drive(4'b1111);
      repeat (2) @(posedge clk);
      #1;
      for (int m = 0; m < 5; m++) check($sformatf("reset out1[%0d]", m), outm[m], 1'b0);
`ifdef COMPARATOR_FLAGS_EN
      check("reset out_eq", out_eq, 1'b0);
      check("reset out_lt", out_lt, 1'b0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].vec);
         @(posedge clk);
         #1;
         for (int m = 0; m < 4; m++)
            check($sformatf("table vec=%b mode%0d", tbl[i].vec, m), outm[m], tbl[i].exp[m]);
      end

      for (int i = 0; i < 16; i++) apply("sweep", 4'(i));

      for (int i = 0; i < 200; i++) apply("random", 4'($urandom_range(0, 15)));

      // Latency: new inputs mid-cycle must not reach out1 before the next edge.
      apply("latency base", 4'b0000);
      drive(4'b1100);
      #3;
      check("latency hold", outm[0], 1'b0);
      @(negedge clk);
      check("latency hold negedge", outm[0], 1'b0);
      @(posedge clk);
      #1;
      check("latency rise", outm[0], 1'b1);

      // Reset mid-stream, including rst rising between edges with no immediate effect.
      apply("pre-reset", 4'b1100);
      #2;
      rst = 1'b1;
      #1;
      check("async rst ignored", outm[0], 1'b1);
      @(posedge clk);
      #1;
      check("mid reset edge", outm[0], 1'b0);
      check("mid reset mode3", outm[3], 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post reset", outm[0], 1'b1);
      check("post reset mode3", outm[3], 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/comparator_2bit_sync.md
Name: comparator_2bit_sync

Overview:
- Two-bit unsigned magnitude comparator with a registered result.
- Operand A = {in1, in2}, operand B = {in3, in4}; in1 and in3 are the MSBs.
- out1 asserts when the selected relation between A and B holds.
- Leaf block used wherever a small synchronous compare flag is needed.

Parameters:
- CMP_MODE, default 0, selects the relation driven on out1: 0 = A>B, 1 = A==B, 2 = A<B, 3 = A>=B. Any other value behaves as 0.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, synchronous and active-high.
- in1  input  1  operand A bit 1 (MSB).
- in2  input  1  operand A bit 0 (LSB).
- in3  input  1  operand B bit 1 (MSB).
- in4  input  1  operand B bit 0 (LSB).
- out1  output  1  registered compare result per CMP_MODE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - When rst=1 at a rising clk edge, out1 becomes 0 (and out_eq/out_lt when present).
  - rst has priority over input sampling in the same cycle.
  - Asynchronous rst assertion between edges has no effect until the next edge.
- Arithmetic:
  - A = 2*in1 + in2 and B = 2*in3 + in4, both unsigned in 0..3.
  - Raw relations: gt = (A>B), eq = (A==B), lt = (A<B). Exactly one of the three is 1 at all times.
  - Result select by CMP_MODE: 0 gives gt, 1 gives eq, 2 gives lt, 3 gives gt|eq.
- Timing:
  - out1 is registered with a latency of 1 cycle.
  - The value sampled at edge N appears on out1 after edge N and holds until edge N+1.
  - No combinational path from inputs to out1.
- No handshake: inputs are sampled on every edge with no enable.
- Boundary cases (CMP_MODE=0):
  - A=B=0 gives out1=0.
  - A=3, B=0 gives out1=1.
  - A=0, B=3 gives out1=0.
  - A=B=3 gives out1=0.
- Reset mid-stream: out1 goes to 0 on the reset edge. The first post-reset result appears one edge after rst deasserts.
- X on any input propagates to out1; no X-masking is required.

Optional Feature:
- Macro: COMPARATOR_FLAGS_EN.
- Defined:
  - Adds two outputs: out_eq (output, 1 bit, registered A==B) and out_lt (output, 1 bit, registered A<B).
  - Both outputs have the same 1-cycle latency and reset value 0 as out1.
  - out1 behaviour is unchanged.
- Undefined: the ports and their registers do not exist, and the port list is exactly as above.

Test Plan:
- Reset: hold rst=1 for 2 edges with all inputs at 1 -> out1=0 (and out_eq=out_lt=0 when COMPARATOR_FLAGS_EN is defined).
- Exhaustive sweep, CMP_MODE=0: apply all 16 {in1,in2,in3,in4} combinations, one per cycle -> out1 equals (A>B) exactly one cycle later. Spot checks: 1000 gives 1, 0010 gives 0, 1111 gives 0.
- Mode sweep: repeat the 16-vector sweep for CMP_MODE=1, 2 and 3 -> out1 tracks eq, lt and ge respectively. Example: A=2, B=2 gives 1, 0, 1.
- Latency: change inputs from 0000 to 1100 just after an edge -> out1 stays 0 until the next edge, then goes to 1.
- Reset mid-operation: with inputs at 1100 and out1=1, pulse rst for one edge -> out1=0 on that edge, back to 1 one edge after rst drops.
- Flags (COMPARATOR_FLAGS_EN defined): sweep all 16 vectors -> out1 (CMP_MODE=0), out_eq and out_lt are one-hot every cycle after reset.
